// File: rtl/seg_data_driver_pkg.sv
// Shared seven-segment display definitions: digit count, blank pattern, hex decode table
// and the display buffer layout used by the cathode driver.
package seg_data_driver_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = $clog2(NUM_DIGITS);

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    // Active-low {a,b,c,d,e,f,g}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_DECODE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,   // F E d C
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,   // b A 9 8
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,   // 7 6 5 4
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001    // 3 2 1 0
    };

    typedef struct packed {
        logic [7:0]  dp;
        logic [31:0] data;
    } disp_buf_t;

    // True when digit idx (idx >= 1) and every more-significant nibble are zero.
    function automatic logic lz_blank(input logic [31:0] data, input logic [SEL_W-1:0] idx);
        logic [31:0] upper;
        upper    = data >> {idx, 2'b00};
        lz_blank = (idx != {SEL_W{1'b0}}) && (upper == 32'h0000_0000);
    endfunction

endpackage

// File: rtl/seg_data_driver_if.sv
// Signal bundle between the display controller (master) and the cathode driver (slave).
interface seg_data_driver_if;
    import seg_data_driver_pkg::*;

    logic [SEL_W-1:0] sel;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [7:0]       wr_dp;
    logic             lz_en;
    logic [6:0]       cathodes;
    logic             dp;
    logic             pending;
    logic             frame_done;

    modport master (
        output sel, wr_en, wr_data, wr_dp, lz_en,
        input  cathodes, dp, pending, frame_done
    );

    modport slave (
        input  sel, wr_en, wr_data, wr_dp, lz_en,
        output cathodes, dp, pending, frame_done
    );

endinterface

// File: rtl/seg_data_driver_hex_to_7seg.sv
// Purely combinational hex nibble to active-low seven-segment decoder.
module seg_data_driver_hex_to_7seg
    import seg_data_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup into the shared decode constant.
    always_comb begin
        seg = SEG_DECODE[nibble];
    end

endmodule

// File: rtl/seg_data_driver.sv
// Cathode driver for the 8-digit display: double-buffered data swapped at frame wrap,
// dead-time blanking after every select change and optional leading-zero blanking.
module seg_data_driver
    import seg_data_driver_pkg::*;
#(
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    seg_data_driver_if.slave bus
);

    localparam logic [7:0] BLANK_LD = 8'(BLANK_CYC);

    disp_buf_t        active_r;
    disp_buf_t        shadow_r;
    logic             pending_r;
    logic [SEL_W-1:0] sel_q_r;
    logic [7:0]       blk_cnt_r;
    logic [6:0]       cathodes_r;
    logic             dp_r;
    logic             frame_done_r;

    logic             chg_s;
    logic             wrap_s;
    logic             blank_s;
    logic             lz_s;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;

    // Select-change, frame-wrap and digit-selection terms for the current cycle.
    always_comb begin
        chg_s    = (bus.sel != sel_q_r);
        wrap_s   = chg_s && (sel_q_r == LAST_SEL) && (bus.sel == {SEL_W{1'b0}});
        blank_s  = chg_s || (blk_cnt_r != 8'd0);
        nibble_s = active_r.data[{sel_q_r, 2'b00} +: 4];
        lz_s     = bus.lz_en && lz_blank(active_r.data, sel_q_r);
    end

    seg_data_driver_hex_to_7seg u_hex_to_7seg (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

    // Buffers, change tracking, dead-time counter and registered segment outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r     <= '0;
            shadow_r     <= '0;
            pending_r    <= 1'b0;
            sel_q_r      <= {SEL_W{1'b0}};
            blk_cnt_r    <= BLANK_LD;
            cathodes_r   <= SEG_BLANK;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            sel_q_r      <= bus.sel;
            frame_done_r <= wrap_s;

            if (chg_s) begin
                blk_cnt_r <= BLANK_LD;
            end else if (blk_cnt_r != 8'd0) begin
                blk_cnt_r <= blk_cnt_r - 8'd1;
            end else begin
                blk_cnt_r <= blk_cnt_r;
            end

            // On a coincident wrap and write the old shadow goes live, the new data stays queued.
            if (wrap_s && pending_r) begin
                active_r <= shadow_r;
            end else begin
                active_r <= active_r;
            end

            if (bus.wr_en) begin
                shadow_r  <= '{dp: bus.wr_dp, data: bus.wr_data};
                pending_r <= 1'b1;
            end else if (wrap_s) begin
                shadow_r  <= shadow_r;
                pending_r <= 1'b0;
            end else begin
                shadow_r  <= shadow_r;
                pending_r <= pending_r;
            end

            if (blank_s) begin
                cathodes_r <= SEG_BLANK;
                dp_r       <= 1'b1;
            end else begin
                cathodes_r <= lz_s ? SEG_BLANK : seg_s;
                dp_r       <= ~active_r.dp[sel_q_r];
            end
        end
    end

    assign bus.cathodes   = cathodes_r;
    assign bus.dp         = dp_r;
    assign bus.pending    = pending_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_data_driver.sv
// Scoreboard bench for seg_data_driver: directed select/write sequences push expected
// outputs into a queue, a negedge monitor pops and compares them.
module tb_seg_data_driver;

    localparam logic [6:0] BLK = 7'h7F;
    localparam logic [6:0] S0  = 7'b0000001;
    localparam logic [6:0] S1  = 7'b1001111;
    localparam logic [6:0] S2  = 7'b0010010;
    localparam logic [6:0] S3  = 7'b0000110;
    localparam logic [6:0] S4  = 7'b1001100;
    localparam logic [6:0] S5  = 7'b0100100;
    localparam logic [6:0] S6  = 7'b0100000;
    localparam logic [6:0] SA  = 7'b0001000;
    localparam logic [6:0] SB  = 7'b1100000;
    localparam logic [6:0] SC  = 7'b0110001;
    localparam logic [6:0] SD  = 7'b1000010;

    typedef struct packed {
        logic [31:0] cyc;
        logic [6:0]  cat;
        logic        dpv;
        logic        pend;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc_cnt = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        drain_req = 1'b0;
    exp_t        exp_q[$];
    string       name_q[$];
    logic [6:0]  frame_a [0:7];
    logic [6:0]  frame_lz [0:7];

    seg_data_driver_if bus();

    seg_data_driver #(.BLANK_CYC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt = cyc_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [6:0] c, input logic d,
                              input logic p, input logic f);
        exp_t e;
        e.cyc  = 32'(cyc_cnt);
        e.cat  = c;
        e.dpv  = d;
        e.pend = p;
        e.fd   = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Dwell 20 clocks on digit d; c/dv is the steady display, p the pending level after the change edge.
    task automatic visit(input logic [2:0] d, input logic [6:0] c, input logic dv,
                         input logic p, input logic f, input logic wr,
                         input logic [31:0] wd, input logic [7:0] wdp);
        bus.sel = d;
        if (wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = wd;
            bus.wr_dp   = wdp;
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            bus.wr_en = 1'b0;
            if (t == 1)
                expect_now($sformatf("sel%0d_change", d), BLK, 1'b1, p, f);
            else if (t == 5)
                expect_now($sformatf("sel%0d_deadtime", d), BLK, 1'b1, p, 1'b0);
            else if (t == 6 || t == 20)
                expect_now($sformatf("sel%0d_show_t%0d", d, t), c, dv, p, 1'b0);
        end
    endtask

    task automatic write(input logic [31:0] wd, input logic [7:0] wdp,
                         input logic [6:0] c, input logic dv);
        bus.wr_en   = 1'b1;
        bus.wr_data = wd;
        bus.wr_dp   = wdp;
        tick();
        bus.wr_en = 1'b0;
        expect_now($sformatf("write_%h", wd), c, dv, 1'b1, 1'b0);
    endtask

    task automatic post_reset_digit0();
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 5) expect_now($sformatf("rst_blank_%0d", k), BLK, 1'b1, 1'b0, 1'b0);
            else       expect_now("rst_digit0", S0, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_now("rst_digit0_hold", S0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare every queued expectation at the negedge of its cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc_cnt) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests = n_tests + 1;
                if (int'(e.cyc) != cyc_cnt ||
                    {bus.cathodes, bus.dp, bus.pending, bus.frame_done} !== {e.cat, e.dpv, e.pend, e.fd}) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: got cat=%b dp=%b pend=%b fd=%b, expected cat=%b dp=%b pend=%b fd=%b (cyc %0d, due %0d)",
                             nm, bus.cathodes, bus.dp, bus.pending, bus.frame_done,
                             e.cat, e.dpv, e.pend, e.fd, cyc_cnt, e.cyc);
                end
            end
            if (drain_req && exp_q.size() != 0) begin
                n_tests = n_tests + 1;
                n_fail  = n_fail + 1;
                $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
                exp_q.delete();
                name_q.delete();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_a[0] = SD; frame_a[1] = SC; frame_a[2] = SB; frame_a[3] = SA;
        frame_a[4] = S4; frame_a[5] = S3; frame_a[6] = S2; frame_a[7] = S1;
        frame_lz[0] = S0;  frame_lz[1] = S0;  frame_lz[2] = S4;  frame_lz[3] = BLK;
        frame_lz[4] = BLK; frame_lz[5] = BLK; frame_lz[6] = BLK; frame_lz[7] = BLK;

        reset       = 1'b1;
        bus.sel     = 3'd0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 32'h0;
        bus.wr_dp   = 8'h00;
        bus.lz_en   = 1'b0;
        tick();
        tick();
        expect_now("reset_values", BLK, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        post_reset_digit0();

        // Write held in shadow until the 7->0 wrap.
        write(32'h1234_ABCD, 8'h01, S0, 1'b1);
        for (int d = 1; d < 8; d++) visit(3'(d), S0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
        visit(3'd0, SD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 8'h00);
        for (int d = 1; d < 8; d++) visit(3'(d), frame_a[d], 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);

        // Latest of two writes wins.
        write(32'h1111_1111, 8'h00, S1, 1'b1);
        write(32'h2222_2222, 8'h00, S1, 1'b1);
        for (int d = 0; d < 8; d++) visit(3'(d), S2, 1'b1, 1'b0, (d == 0), 1'b0, 32'h0, 8'h00);

        // Write coincident with the wrap edge.
        write(32'h0000_0005, 8'h00, S2, 1'b1);
        visit(3'd0, S5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0006, 8'h00);
        for (int d = 1; d < 8; d++) visit(3'(d), S0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
        visit(3'd0, S6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 8'h00);

        // Leading-zero blanking, dp still follows its mask on a blanked digit.
        write(32'h0000_0400, 8'h80, S6, 1'b1);
        for (int d = 1; d < 8; d++) visit(3'(d), S0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
        bus.lz_en = 1'b1;
        for (int d = 0; d < 8; d++) visit(3'(d), frame_lz[d], (d != 7), 1'b0, (d == 0), 1'b0, 32'h0, 8'h00);
        bus.lz_en = 1'b0;
        for (int d = 0; d < 8; d++) visit(3'(d), (d == 2) ? S4 : S0, (d != 7), 1'b0, (d == 0), 1'b0, 32'h0, 8'h00);

        // Non-wrapping jump with a pending write, then reset in the blank window.
        write(32'hFFFF_FFFF, 8'hFF, S0, 1'b0);
        bus.sel = 3'd3;
        tick();
        expect_now("jump_7_to_3", BLK, 1'b1, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        expect_now("async_reset", BLK, 1'b1, 1'b0, 1'b0);
        bus.sel = 3'd0;
        tick();
        reset = 1'b0;
        post_reset_digit0();
        for (int d = 1; d < 8; d++) visit(3'(d), S0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
        visit(3'd0, S0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 8'h00);

        tick();
        drain_req = 1'b1;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_data_driver.md
# seg_data_driver

Cathode-side companion to the anode scanner of the 8-digit seven-segment display. It consumes the 3-bit digit select from the anode scanner and drives the active-low segment and decimal-point lines for the digit currently enabled. Display data is double-buffered and swapped only at frame wrap, so a write never tears a frame. The block blanks the segments for a programmable dead time after each digit change to suppress ghosting, and optionally blanks leading zeros.

## Interface
- BLANK_CYC, 4: dead-time clocks after each select change; legal range 1–255.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- sel  in  3  digit select from the anode scanner; 0 = rightmost digit (nibble [3:0]).
- wr_en  in  1  one-cycle write strobe for wr_data/wr_dp.
- wr_data  in  32  eight hex nibbles; nibble i = digit i.
- wr_dp  in  8  decimal-point mask, active-high; bit i = digit i.
- lz_en  in  1  leading-zero blanking enable; sampled every cycle.
- cathodes  out  7  segments {a,b,c,d,e,f,g}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- pending  out  1  shadow buffer holds data not yet displayed.
- frame_done  out  1  one-cycle pulse at each 7→0 select wrap.

## Operation
- Registers:
  - active buffer (32+8 bits) and shadow buffer (32+8 bits).
  - pending flag.
  - sel_q, holding the previous select.
  - 8-bit blank counter blk_cnt.
- Write: wr_en=1 loads shadow ← {wr_dp, wr_data} and sets pending=1. When pending is already 1, the latest write wins.
- Change detect: chg = (sel != sel_q). sel_q ← sel every cycle.
- Wrap: wrap = chg & (sel_q==7) & (sel==0).
  - frame_done ← wrap, regardless of pending.
  - If wrap & pending: active ← shadow, pending ← 0.
- Wrap and wr_en in the same cycle:
  - active takes the old shadow.
  - shadow takes the new data.
  - pending ends at 1.
- Blanking:
  - chg loads blk_cnt ← BLANK_CYC.
  - Otherwise blk_cnt decrements while nonzero.
  - While chg=1 or blk_cnt≠0, outputs are cathodes=7'h7F and dp=1.
- Display (chg=0 and blk_cnt=0):
  - cathodes ← decode(active nibble[sel_q]).
  - dp ← ~active_dp[sel_q].
- Leading-zero rule: with lz_en=1, digit i (i≥1) is blanked when nibbles 7..i are all zero. In that case cathodes=7'h7F, while dp still follows the mask. Digit 0 is never blanked.
- Decode table (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- A non-wrapping select jump (e.g. 3→6) is treated as an ordinary change: blank, no swap.

## Timing
- Reset values:
  - cathodes=7'h7F, dp=1, frame_done=0, pending=0.
  - active=0, shadow=0, sel_q=0, blk_cnt=BLANK_CYC.
- After reset deasserts with sel held at 0, the outputs show digit 0 = "0" on the clock edge where blk_cnt reaches 0, i.e. BLANK_CYC+1 edges later.
- Select-change to valid segments: blanked for BLANK_CYC+1 cycles after the sel change edge, then valid.
- Write to visible: the write is never visible before the next wrap. After the wrap, it is visible once the blank window ends.
- pending rises on the edge after wr_en and falls on the edge after the swapping wrap.
- Reset mid-frame discards both buffers and any pending write immediately (asynchronous).
- Every output is a flop; there is no combinational path from inputs to outputs.

## Structure
- The shared display package holds:
  - NUM_DIGITS=8.
  - the SEG_BLANK=7'h7F constant.
  - the 16-entry segment decode constant array, shared with any other seven-segment user.
- Natural sub-module: hex_to_7seg, a purely combinational nibble→cathode decoder.
- The buffering, change detection, blank counter and leading-zero logic live in this block.

## Test plan
- Reset, sel held 0, BLANK_CYC=4: cathodes=7F and dp=1 for 5 cycles, then cathodes=0000001 and dp=1. pending=0, frame_done never pulses.
- Write 32'h1234_ABCD with dp=8'h01 while sel cycles 0..7 every 20 clocks: pending=1 and the display stays old until the 7→0 wrap. At the wrap, frame_done pulses once and pending drops. Digit 0 then shows D (1000010) with dp=0, digit 7 shows 1 (1001111), and each digit is blanked for 5 cycles after its change.
- Two writes (32'h11111111, then 32'h22222222) before one wrap: after the wrap every digit shows 2 (0010010).
- wr_en coincident with the wrap edge (old shadow 32'h5, new 32'h6): the displayed value is 5, pending stays 1, and the next wrap shows 6.
- lz_en=1 with data 32'h0000_0400: digits 7..3 give cathodes=7F, digit 2 shows 4, digits 1 and 0 show 0. With lz_en=0, all eight digits are lit.
- Assert reset mid-blank with pending=1: outputs return to reset values immediately, pending=0, and the post-reset frame shows all zeros.
